// File: rtl/proc_multicycle_pkg.sv
// Shared types for the multicycle processor:
// opcodes, FSM states, bus selects, decoder.
package proc_multicycle_pkg;

    localparam int IW = 9;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_MVNZ = 3'b110,
        OP_AND  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_DEC,
        S_E1,
        S_E2,
        S_E3
    } state_t;

    typedef enum logic [2:0] {
        BUS_DIN,
        BUS_RX,
        BUS_RY,
        BUS_G,
        BUS_PC
    } bus_sel_t;

    function automatic logic [7:0] dec3to8(input logic [2:0] s);
        dec3to8 = 8'b1 << s;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// ALU for add/sub/and with zero detect.
// Result wraps modulo 2^DW.
module proc_alu
    import proc_multicycle_pkg::*;
#(
    parameter int DW = 16
) (
    input  opcode_t         op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   y,
    output logic            zero
);

    // result select and zero flag
    always_comb begin
        y = a + b;
        unique case (op)
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            default: y = a + b;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/proc_multicycle.sv
// Multicycle processor: 8-reg file (R7 = PC),
// A/G datapath, self-fetching FSM.
module proc_multicycle
    import proc_multicycle_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic            P_clock,
    input  logic            resetn,
    input  logic            run,
    input  logic [DW-1:0]   DIN,
    output logic [AW-1:0]   ADDR,
    output logic [DW-1:0]   DOUT,
    output logic            W,
    output logic            done,
    output logic [DW-1:0]   BusWires
);

    state_t         state;
    state_t         state_n;
    bus_sel_t       bus_sel;
    logic [IW-1:0]  ir;
    opcode_t        op;
    logic [2:0]     rx;
    logic [2:0]     ry;
    logic [7:0]     rx_oh;
    logic [7:0]     ry_oh;
    logic [DW-1:0]  r [8];
    logic [DW-1:0]  rx_val;
    logic [DW-1:0]  ry_val;
    logic [DW-1:0]  a;
    logic [DW-1:0]  g;
    logic [DW-1:0]  alu_y;
    logic           alu_z;
    logic           z_flag;
    logic           w_q;
    logic           rf_we;
    logic           a_we;
    logic           g_we;
    logic           ir_we;
    logic           pc_inc;
    logic           addr_we;
    logic           dout_we;
    logic           w_set;
    logic           last;

    assign op    = opcode_t'(ir[8:6]);
    assign rx    = ir[5:3];
    assign ry    = ir[2:0];
    assign rx_oh = dec3to8(rx);
    assign ry_oh = dec3to8(ry);

    // reset masks the last-cycle strobes so an aborted instruction never signals
    assign done = last & ~resetn;
    assign W    = w_q & ~resetn;

    // one-hot register read ports
    always_comb begin
        rx_val = '0;
        ry_val = '0;
        for (int i = 0; i < 8; i++) begin
            if (rx_oh[i]) rx_val |= r[i];
            if (ry_oh[i]) ry_val |= r[i];
        end
    end

    // single-driver bus, DIN when nothing else drives
    always_comb begin
        unique case (bus_sel)
            BUS_RX:  BusWires = rx_val;
            BUS_RY:  BusWires = ry_val;
            BUS_G:   BusWires = g;
            BUS_PC:  BusWires = r[7];
            default: BusWires = DIN;
        endcase
    end

    proc_alu #(.DW(DW)) u_alu (
        .op   (op),
        .a    (a),
        .b    (BusWires),
        .y    (alu_y),
        .zero (alu_z)
    );

    // FSM state register
    always_ff @(posedge P_clock) begin
        if (resetn) state <= S_IDLE;
        else        state <= state_n;
    end

    // next state and datapath controls
    always_comb begin
        state_n = state;
        bus_sel = BUS_DIN;
        rf_we   = 1'b0;
        a_we    = 1'b0;
        g_we    = 1'b0;
        ir_we   = 1'b0;
        pc_inc  = 1'b0;
        addr_we = 1'b0;
        dout_we = 1'b0;
        w_set   = 1'b0;
        last    = 1'b0;
        unique case (state)
            S_IDLE: if (run) state_n = S_F0;
            S_F0: begin
                bus_sel = BUS_PC;
                addr_we = 1'b1;
                pc_inc  = 1'b1;
                state_n = S_F1;
            end
            S_F1:  state_n = S_DEC;
            S_DEC: begin
                ir_we   = 1'b1;
                state_n = S_E1;
            end
            S_E1: begin
                state_n = S_E2;
                unique case (op)
                    OP_MV: begin
                        bus_sel = BUS_RY;
                        rf_we   = 1'b1;
                        last    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = BUS_PC;
                        addr_we = 1'b1;
                        pc_inc  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_sel = BUS_RX;
                        a_we    = 1'b1;
                    end
                    OP_LD: begin
                        bus_sel = BUS_RY;
                        addr_we = 1'b1;
                    end
                    OP_ST: begin
                        bus_sel = BUS_RY;
                        addr_we = 1'b1;
                        dout_we = 1'b1;
                        w_set   = 1'b1;
                    end
                    OP_MVNZ: begin
                        bus_sel = BUS_RY;
                        rf_we   = ~z_flag;
                        last    = 1'b1;
                    end
                endcase
            end
            S_E2: begin
                state_n = S_E3;
                unique case (op)
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_sel = BUS_RY;
                        g_we    = 1'b1;
                    end
                    OP_ST:   last = 1'b1;
                    default: ;
                endcase
            end
            S_E3: begin
                last = 1'b1;
                unique case (op)
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_sel = BUS_G;
                        rf_we   = 1'b1;
                    end
                    OP_MVI, OP_LD: rf_we = 1'b1;
                    default: ;
                endcase
            end
            default: state_n = S_IDLE;
        endcase
        if (last) state_n = run ? S_F0 : S_IDLE;
    end

    // register file, A/G, IR and memory interface registers
    always_ff @(posedge P_clock) begin
        if (resetn) begin
            for (int i = 0; i < 8; i++) r[i] <= '0;
            a      <= '0;
            g      <= '0;
            z_flag <= 1'b1;
            ir     <= '0;
            ADDR   <= '0;
            DOUT   <= '0;
            w_q    <= 1'b0;
        end else begin
            if (ir_we)   ir   <= DIN[DW-1 -: IW];
            if (a_we)    a    <= BusWires;
            if (addr_we) ADDR <= BusWires[AW-1:0];
            if (dout_we) DOUT <= rx_val;
            if (g_we) begin
                g      <= alu_y;
                z_flag <= alu_z;
            end
            w_q <= w_set;
            for (int i = 0; i < 8; i++) begin
                if (rf_we && rx_oh[i])
                    r[i] <= BusWires;
                else if (pc_inc && i == 7)
                    r[i] <= r[i] + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_proc_multicycle.sv
// Bench for proc_multicycle: directed programs,
// ALU table and random programs against an ISA model.
module tb_proc_multicycle;

    logic        P_clock = 1'b0;
    logic        resetn  = 1'b1;
    logic        run     = 1'b0;
    logic [15:0] DIN     = 16'h0;
    logic [4:0]  ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic        done;
    logic [15:0] BusWires;

    proc_multicycle #(.DW(16), .AW(5)) dut (
        .P_clock  (P_clock),
        .resetn   (resetn),
        .run      (run),
        .DIN      (DIN),
        .ADDR     (ADDR),
        .DOUT     (DOUT),
        .W        (W),
        .done     (done),
        .BusWires (BusWires)
    );

    always #5 P_clock = ~P_clock;

    logic [15:0] mem [32];

    // synchronous memory, 1-cycle read
    always @(posedge P_clock) begin
        if (W) mem[ADDR] <= DOUT;
        DIN <= mem[ADDR];
    end

    int          w_cycles  = 0;
    int          done_seen = 0;
    logic [4:0]  w_addr    = 5'h0;
    logic [15:0] w_dout    = 16'h0;

    // observe write strobes and done pulses
    always @(negedge P_clock) begin
        if (W) begin
            w_cycles <= w_cycles + 1;
            w_addr   <= ADDR;
            w_dout   <= DOUT;
        end
        if (done) done_seen <= done_seen + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op,
                                        input int x,
                                        input int y);
        logic [2:0] o3, x3, y3;
        o3 = op[2:0];
        x3 = x[2:0];
        y3 = y[2:0];
        return {o3, x3, y3, 7'b0};
    endfunction

    function automatic logic [15:0] rd(input int i);
        return dut.r[i];
    endfunction

    task automatic begin_test();
        @(negedge P_clock);
        resetn = 1'b1;
        run    = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    endtask

    task automatic go();
        repeat (2) @(posedge P_clock);
        @(negedge P_clock);
        resetn = 1'b0;
        run    = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget,
                             input string name);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge P_clock);
            if (done) got++;
        end
        if (got < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, %0d of %0d done pulses",
                     name, got, n);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
    } alu_vec_t;

    alu_vec_t tbl [7];

    logic [15:0] mr [8];
    logic [15:0] mm [32];
    logic        mz;

    // one instruction of the ISA, returns its cycle count
    task automatic model_step(output int ec);
        logic [15:0] ir, v;
        logic [2:0]  op, x, y;
        ir    = mm[mr[7][4:0]];
        mr[7] = mr[7] + 16'd1;
        op    = ir[15:13];
        x     = ir[12:10];
        y     = ir[9:7];
        ec    = 6;
        case (op)
            3'd0: begin mr[x] = mr[y]; ec = 4; end
            3'd1: begin
                v     = mm[mr[7][4:0]];
                mr[7] = mr[7] + 16'd1;
                mr[x] = v;
            end
            3'd2: begin v = mr[x] + mr[y]; mz = (v == 0); mr[x] = v; end
            3'd3: begin v = mr[x] - mr[y]; mz = (v == 0); mr[x] = v; end
            3'd7: begin v = mr[x] & mr[y]; mz = (v == 0); mr[x] = v; end
            3'd4: mr[x] = mm[mr[y][4:0]];
            3'd5: begin mm[mr[y][4:0]] = mr[x]; ec = 5; end
            default: begin if (!mz) mr[x] = mr[y]; ec = 4; end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dk, dc, w0, ds, cyc, ec;
        logic got;

        for (int i = 0; i < 32; i++) mem[i] = 16'h0;

        // reset state
        repeat (2) @(posedge P_clock);
        #1;
        for (int i = 0; i < 8; i++)
            check($sformatf("rst_r%0d", i), rd(i), 16'h0);
        check("rst_addr", 16'(ADDR), 16'h0);
        check("rst_dout", DOUT, 16'h0);
        check("rst_w", 16'(W), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_z", 16'(dut.z_flag), 16'h1);
        check("rst_bus_din", BusWires, DIN);

        // mvi R0,#5 timing
        begin_test();
        mem[0] = enc(1, 0, 0);
        mem[1] = 16'h0005;
        mem[2] = enc(1, 7, 0);
        mem[3] = 16'h0002;
        go();
        dk = -1;
        dc = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge P_clock);
            @(negedge P_clock);
            if (done) begin dc++; dk = k; end
        end
        check("t1_done_cnt", 16'(dc), 16'd1);
        check("t1_done_cyc", 16'(dk), 16'd5);
        check("t1_r0", rd(0), 16'h0005);
        check("t1_r7", rd(7), 16'h0002);

        // ALU table
        tbl[0] = '{3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[1] = '{3'd3, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
        tbl[2] = '{3'd7, 16'h00F0, 16'h0F0F, 16'h0000, 1'b1};
        tbl[3] = '{3'd7, 16'hFF0F, 16'h0FF0, 16'h0F00, 1'b0};
        tbl[4] = '{3'd2, 16'h1234, 16'h4321, 16'h5555, 1'b0};
        tbl[5] = '{3'd3, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        tbl[6] = '{3'd3, 16'h0005, 16'h0007, 16'hFFFE, 1'b0};
        for (int t = 0; t < 7; t++) begin
            begin_test();
            mem[0] = enc(1, 1, 0);
            mem[1] = tbl[t].a;
            mem[2] = enc(1, 2, 0);
            mem[3] = tbl[t].b;
            mem[4] = enc(int'(tbl[t].op), 1, 2);
            mem[5] = enc(1, 7, 0);
            mem[6] = 16'h0005;
            go();
            wait_done(3, 40, $sformatf("alu%0d", t));
            @(posedge P_clock);
            #1;
            check($sformatf("alu%0d_res", t), rd(1), tbl[t].res);
            check($sformatf("alu%0d_z", t), 16'(dut.z_flag),
                  16'(tbl[t].z));
        end

        // run control
        begin_test();
        mem[0] = enc(1, 1, 0);
        mem[1] = 16'h0007;
        mem[2] = enc(1, 2, 0);
        mem[3] = 16'h0009;
        mem[4] = enc(1, 7, 0);
        mem[5] = 16'h0004;
        go();
        wait_done(1, 20, "run_first");
        run = 1'b0;
        dc = 0;
        repeat (12) begin
            @(negedge P_clock);
            if (done) dc++;
        end
        check("run_idle_done", 16'(dc), 16'd0);
        check("run_idle_r1", rd(1), 16'h0007);
        check("run_idle_r2", rd(2), 16'h0000);
        check("run_idle_r7", rd(7), 16'h0002);
        check("run_idle_addr", 16'(ADDR), 16'h0001);
        run = 1'b1;
        wait_done(1, 20, "run_resume");
        @(posedge P_clock);
        #1;
        check("run_resume_r2", rd(2), 16'h0009);
        check("run_resume_r7", rd(7), 16'h0004);

        // st then ld
        begin_test();
        mem[0] = enc(1, 3, 0);
        mem[1] = 16'h0010;
        mem[2] = enc(1, 4, 0);
        mem[3] = 16'h00AB;
        mem[4] = enc(5, 4, 3);
        mem[5] = enc(4, 5, 3);
        mem[6] = enc(1, 7, 0);
        mem[7] = 16'h0006;
        w0 = w_cycles;
        go();
        wait_done(4, 60, "stld");
        @(posedge P_clock);
        #1;
        check("st_w_cycles", 16'(w_cycles - w0), 16'd1);
        check("st_addr", 16'(w_addr), 16'h0010);
        check("st_dout", w_dout, 16'h00AB);
        check("st_mem", mem[16], 16'h00AB);
        check("ld_r5", rd(5), 16'h00AB);

        // countdown loop with mvnz branch
        begin_test();
        mem[0]  = enc(1, 0, 0);
        mem[1]  = 16'h0003;
        mem[2]  = enc(1, 1, 0);
        mem[3]  = 16'h0001;
        mem[4]  = enc(1, 6, 0);
        mem[5]  = 16'h0008;
        mem[6]  = enc(1, 2, 0);
        mem[7]  = 16'h0000;
        mem[8]  = enc(2, 2, 1);
        mem[9]  = enc(3, 0, 1);
        mem[10] = enc(6, 7, 6);
        mem[11] = enc(1, 7, 0);
        mem[12] = 16'h000B;
        go();
        repeat (200) @(negedge P_clock);
        check("loop_r0", rd(0), 16'h0000);
        check("loop_count", rd(2), 16'h0003);
        check("loop_z", 16'(dut.z_flag), 16'h1);

        // PC wrap at 2^16 and fetch wrap at 2^AW
        begin_test();
        mem[0]  = enc(1, 7, 0);
        mem[1]  = 16'hFFFF;
        mem[2]  = enc(1, 7, 0);
        mem[3]  = 16'h0002;
        mem[31] = enc(1, 1, 0);
        go();
        wait_done(4, 60, "wrap");
        @(posedge P_clock);
        #1;
        check("wrap_r1", rd(1), enc(1, 7, 0));
        check("wrap_and_r7", rd(7), 16'h0002);

        // reset during add E2
        begin_test();
        mem[0] = enc(1, 1, 0);
        mem[1] = 16'h0005;
        mem[2] = enc(1, 2, 0);
        mem[3] = 16'h0003;
        mem[4] = enc(2, 1, 2);
        mem[5] = enc(1, 7, 0);
        mem[6] = 16'h0005;
        go();
        wait_done(2, 40, "rst_mid");
        repeat (5) @(posedge P_clock);
        @(negedge P_clock);
        resetn = 1'b1;
        ds = done_seen;
        @(posedge P_clock);
        #1;
        for (int i = 0; i < 8; i++)
            check($sformatf("rstmid_r%0d", i), rd(i), 16'h0);
        check("rstmid_a", dut.a, 16'h0);
        check("rstmid_g", dut.g, 16'h0);
        check("rstmid_z", 16'(dut.z_flag), 16'h1);
        repeat (3) @(negedge P_clock);
        check("rstmid_no_done", 16'(done_seen - ds), 16'd0);

        // random programs against ISA model
        for (int p = 0; p < 3; p++) begin
            begin_test();
            for (int i = 0; i < 32; i++) begin
                mem[i] = 16'($urandom);
                mm[i]  = mem[i];
            end
            for (int i = 0; i < 8; i++) mr[i] = 16'h0;
            mz = 1'b1;
            go();
            for (int n = 0; n < 60; n++) begin
                cyc = 0;
                got = 1'b0;
                while (!got && cyc < 12) begin
                    @(negedge P_clock);
                    cyc++;
                    if (done) got = 1'b1;
                end
                if (!got) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rnd%0d_%0d: no done pulse", p, n);
                    break;
                end
                model_step(ec);
                check($sformatf("rnd%0d_%0d_cyc", p, n),
                      16'(cyc), 16'(ec));
                @(posedge P_clock);
                #1;
                for (int i = 0; i < 8; i++)
                    check($sformatf("rnd%0d_%0d_r%0d", p, n, i),
                          rd(i), mr[i]);
                check($sformatf("rnd%0d_%0d_z", p, n),
                      16'(dut.z_flag), 16'(mz));
            end
            for (int i = 0; i < 32; i++)
                check($sformatf("rnd%0d_mem%0d", p, i), mem[i], mm[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
